// File: rtl/ssd_multiplex_driver.sv
// N-digit seven-segment scan multiplexer: double-buffered 5-bit glyph codes, per-digit blink and
// decimal point, 16-level PWM brightness and a frame tick. Anode/cathode outputs are registered.
module ssd_multiplex_driver #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_DIV   = 17,
    parameter int unsigned BLINK_DIV  = 26,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [5*N_DIGITS-1:0]         digits_in,
    input  logic                          load,
    input  logic [N_DIGITS-1:0]           blink_mask,
    input  logic [N_DIGITS-1:0]           dp_mask,
    input  logic [3:0]                    bright,
    input  logic                          enable,
    output logic [N_DIGITS-1:0]           An,
    output logic [7:0]                    Cathodes,
    output logic [$clog2(N_DIGITS)-1:0]   scan_idx,
    output logic                          frame_tick
);

    localparam int unsigned IDX_W   = $clog2(N_DIGITS);
    localparam int unsigned CODES_W = 5 * N_DIGITS;

    localparam logic [4:0]          CODE_BLANK = 5'b10000;
    localparam logic [CODES_W-1:0]  ALL_BLANK  = {N_DIGITS{CODE_BLANK}};
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_DIGITS - 1);
    // XOR masks that turn internal active-high drives into pin polarity; also the "off" levels.
    localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]          CATH_OFF   = {8{ACTIVE_LOW}};

    logic [SCAN_DIV-1:0]  prescaler;
    logic [BLINK_DIV-1:0] blink_cnt;
    logic [CODES_W-1:0]   shadow;
    logic [CODES_W-1:0]   active;

    logic slot_end;
    logic frame_end;

    assign slot_end  = &prescaler;
    assign frame_end = slot_end && (scan_idx == LAST_IDX);

    // Timebase: slot prescaler, scan index, blink counter and frame tick.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prescaler  <= '0;
            blink_cnt  <= '0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
        end else begin
            prescaler  <= prescaler + SCAN_DIV'(1);
            blink_cnt  <= blink_cnt + BLINK_DIV'(1);
            frame_tick <= frame_end;
            if (slot_end) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
            end
        end
    end

    // Shadow collects loads; active only changes on a frame boundary so a frame never tears.
    // A load on the boundary cycle itself goes straight to active.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shadow <= ALL_BLANK;
            active <= ALL_BLANK;
        end else begin
            if (load) begin
                shadow <= digits_in;
            end
            if (frame_end) begin
                active <= load ? digits_in : shadow;
            end
        end
    end

    logic [4:0]          cur_code;
    logic                cur_blink;
    logic                cur_dp;
    logic [N_DIGITS-1:0] cur_onehot;

    always_comb begin
        cur_code   = CODE_BLANK;
        cur_blink  = 1'b0;
        cur_dp     = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_code      = active[5*k +: 5];
                cur_blink     = blink_mask[k];
                cur_dp        = dp_mask[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    // Segments in active-high {a,b,c,d,e,f,g} form.
    logic [6:0] seg_on;
    logic       glyph_blank;

    always_comb begin
        seg_on      = 7'b0000000;
        glyph_blank = 1'b0;
        case (cur_code)
            5'h00:   seg_on = 7'b1111110;
            5'h01:   seg_on = 7'b0110000;
            5'h02:   seg_on = 7'b1101101;
            5'h03:   seg_on = 7'b1111001;
            5'h04:   seg_on = 7'b0110011;
            5'h05:   seg_on = 7'b1011011;
            5'h06:   seg_on = 7'b1011111;
            5'h07:   seg_on = 7'b1110000;
            5'h08:   seg_on = 7'b1111111;
            5'h09:   seg_on = 7'b1111011;
            5'h0A:   seg_on = 7'b1110111;
            5'h0B:   seg_on = 7'b0011111;
            5'h0C:   seg_on = 7'b1001110;
            5'h0D:   seg_on = 7'b0111101;
            5'h0E:   seg_on = 7'b1001111;
            5'h0F:   seg_on = 7'b1000111;
            5'h11:   seg_on = 7'b0111011;  // Y
            5'h12:   seg_on = 7'b1111101;  // a
            5'h13:   seg_on = 7'b0001110;  // L
            default: glyph_blank = 1'b1;
        endcase
    end

    logic [3:0]          pwm_sub;
    logic                pwm_on;
    logic                blinked;
    logic                drive;
    logic [N_DIGITS-1:0] an_hi;
    logic [7:0]          cath_hi;
    logic [N_DIGITS-1:0] an_d;
    logic [7:0]          cath_d;

    assign pwm_sub = prescaler[SCAN_DIV-1 -: 4];
    assign pwm_on  = (pwm_sub <= bright);
    assign blinked = blink_cnt[BLINK_DIV-1] & cur_blink;
    assign drive   = enable & pwm_on & ~blinked;

    always_comb begin
        an_hi   = '0;
        cath_hi = 8'h00;
        if (drive) begin
            an_hi = cur_onehot;
            // A blank code keeps the decimal point dark as well.
            if (!glyph_blank) begin
                cath_hi = {seg_on, cur_dp};
            end
        end
        an_d   = an_hi ^ AN_OFF;
        cath_d = cath_hi ^ CATH_OFF;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            An       <= AN_OFF;
            Cathodes <= CATH_OFF;
        end else begin
            An       <= an_d;
            Cathodes <= cath_d;
        end
    end

endmodule
